// File: rtl/alu_writeback_if.sv
// Handshake bundle between the ALU (push side) and the register-file write port (commit side).
// master = environment driving pushes and wr_ready; slave = the writeback stage.
interface alu_writeback_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       in_flags;
    logic [AW-1:0]    in_dest;
    logic             in_we;

    logic             wr_valid;
    logic             wr_ready;
    logic             wr_we;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output in_valid, in_data, in_flags, in_dest, in_we,
        input  in_ready,
        input  wr_valid, wr_we, wr_addr, wr_data,
        output wr_ready
    );

    modport slave (
        input  in_valid, in_data, in_flags, in_dest, in_we,
        output in_ready,
        output wr_valid, wr_we, wr_addr, wr_data,
        input  wr_ready
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry skid FIFO feeding the register-file write port, status flags,
// sticky overflow and a forwarding tap. Optional push-time saturation under `ALU_WB_SAT_EN.
module alu_writeback #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             n_reset,
    alu_writeback_if.slave   bus,
    input  logic             clr_sticky,
    output logic [3:0]       stat_flags,
    output logic             stat_ovf_sticky,
    output logic             fwd_valid,
    output logic [AW-1:0]    fwd_addr,
    output logic [WIDTH-1:0] fwd_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] ent_data  [2];
    logic [3:0]       ent_flags [2];
    logic [AW-1:0]    ent_dest  [2];
    logic             ent_we    [2];

    logic             head;
    logic             tail;
    logic             young;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] st_data;
    logic [3:0]       st_flags;

    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = bus.wr_valid && bus.wr_ready;
    // tail sits one slot past the head when one entry is held
    assign tail  = head ^ count[0];
    assign young = head ^ (count == 2'd2);

    always_comb begin
        st_data  = bus.in_data;
        st_flags = bus.in_flags;
`ifdef ALU_WB_SAT_EN
        if (bus.in_flags[0]) begin
            // a wrapped-negative result really overflowed upward, so clamp to the max positive
            if (bus.in_flags[3]) begin
                st_data = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                st_data = {1'b1, {(WIDTH-1){1'b0}}};
            end
            st_flags = {~bus.in_flags[3], 1'b0, bus.in_flags[1], 1'b1};
        end
`endif
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count           <= 2'd0;
            head            <= 1'b0;
            stat_flags      <= 4'd0;
            stat_ovf_sticky <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ent_data[i]  <= '0;
                ent_flags[i] <= 4'd0;
                ent_dest[i]  <= '0;
                ent_we[i]    <= 1'b0;
            end
        end else begin
            if (push) begin
                ent_data[tail]  <= st_data;
                ent_flags[tail] <= st_flags;
                ent_dest[tail]  <= bus.in_dest;
                ent_we[tail]    <= bus.in_we;
            end
            if (pop) begin
                head       <= ~head;
                stat_flags <= ent_flags[head];
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (pop && ent_flags[head][0]) begin
                stat_ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                stat_ovf_sticky <= 1'b0;
            end
        end
    end

    // in_ready comes only from registered occupancy; no pass-through when full
    assign bus.in_ready = (count != 2'd2);
    assign bus.wr_valid = (count != 2'd0);
    assign bus.wr_we    = bus.wr_valid && ent_we[head];
    assign bus.wr_addr  = bus.wr_valid ? ent_dest[head] : '0;
    assign bus.wr_data  = bus.wr_valid ? ent_data[head] : '0;

    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_data  = '0;
        if ((count != 2'd0) && ent_we[young]) begin
            fwd_valid = 1'b1;
            fwd_addr  = ent_dest[young];
            fwd_data  = ent_data[young];
        end else if ((count == 2'd2) && ent_we[head]) begin
            fwd_valid = 1'b1;
            fwd_addr  = ent_dest[head];
            fwd_data  = ent_data[head];
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: directed scenarios followed by random traffic.
module tb_alu_writeback;
    localparam int WIDTH = 8;
    localparam int AW    = 3;
`ifdef ALU_WB_SAT_EN
    localparam logic [7:0] OVF_DATA  = 8'h7F;
    localparam logic [3:0] OVF_FLAGS = 4'b0001;
`else
    localparam logic [7:0] OVF_DATA  = 8'h90;
    localparam logic [3:0] OVF_FLAGS = 4'b1001;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [3:0]       flags;
        logic [AW-1:0]    dest;
        logic             we;
    } ent_t;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             clr_sticky = 1'b0;
    logic [3:0]       stat_flags;
    logic             stat_ovf_sticky;
    logic             fwd_valid;
    logic [AW-1:0]    fwd_addr;
    logic [WIDTH-1:0] fwd_data;
    logic [1:0]       count;

    alu_writeback_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    alu_writeback #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk),
        .n_reset(n_reset),
        .bus(bus),
        .clr_sticky(clr_sticky),
        .stat_flags(stat_flags),
        .stat_ovf_sticky(stat_ovf_sticky),
        .fwd_valid(fwd_valid),
        .fwd_addr(fwd_addr),
        .fwd_data(fwd_data),
        .count(count)
    );

    always #5 clk = ~clk;

    ent_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] m_flags = 4'd0;
    logic       m_sticky = 1'b0;
    logic       push_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // What the stage should hold for an accepted push, from the arithmetic rules
    function automatic ent_t model_store(input logic [WIDTH-1:0] d, input logic [3:0] f,
                                         input logic [AW-1:0] a, input logic we);
        ent_t e;
        e.data  = d;
        e.flags = f;
        e.dest  = a;
        e.we    = we;
`ifdef ALU_WB_SAT_EN
        if (f[0]) begin
            int sat;
            sat     = f[3] ? ((1 << (WIDTH - 1)) - 1) : -(1 << (WIDTH - 1));
            e.data  = sat[WIDTH-1:0];
            e.flags = {sat < 0, 1'b0, f[1], 1'b1};
        end
`endif
        return e;
    endfunction

    always @(negedge clk) push_pend = n_reset && bus.in_valid && bus.in_ready;

    always @(posedge clk) begin
        if (push_pend && n_reset)
            q.push_back(model_store(bus.in_data, bus.in_flags, bus.in_dest, bus.in_we));
    end

    // Monitor: compares visible state with the model and retires committed entries
    always @(negedge clk) begin
        if (n_reset) begin
            logic             fv;
            logic [AW-1:0]    fa;
            logic [WIDTH-1:0] fd;
            ent_t             h;
            check("count", 32'(count), 32'(q.size()));
            check("in_ready", 32'(bus.in_ready), 32'(q.size() != 2));
            check("wr_valid", 32'(bus.wr_valid), 32'(q.size() != 0));
            check("stat_flags", 32'(stat_flags), 32'(m_flags));
            check("sticky", 32'(stat_ovf_sticky), 32'(m_sticky));
            fv = 1'b0;
            fa = '0;
            fd = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].we && !fv) begin
                    fv = 1'b1;
                    fa = q[i].dest;
                    fd = q[i].data;
                end
            end
            check("fwd_valid", 32'(fwd_valid), 32'(fv));
            if (fv) begin
                check("fwd_addr", 32'(fwd_addr), 32'(fa));
                check("fwd_data", 32'(fwd_data), 32'(fd));
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL commit_empty: got a commit, expected none at %0t", $time);
                end else begin
                    h = q.pop_front();
                    check("wr_we", 32'(bus.wr_we), 32'(h.we));
                    check("wr_addr", 32'(bus.wr_addr), 32'(h.dest));
                    check("wr_data", 32'(bus.wr_data), 32'(h.data));
                    m_flags = h.flags;
                    if (h.flags[0]) m_sticky = 1'b1;
                    else if (clr_sticky) m_sticky = 1'b0;
                end
            end else if (clr_sticky) begin
                m_sticky = 1'b0;
            end
        end
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [3:0] f,
                         input logic [AW-1:0] a, input logic we, input logic rdy, input logic clr);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_flags = f;
        bus.in_dest  = a;
        bus.in_we    = we;
        bus.wr_ready = rdy;
        clr_sticky   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, 4'd0, '0, 1'b0, rdy, 1'b0);
    endtask

    task automatic single_push_scenario();
        drive(1'b1, 8'h2A, 4'd0, 3'd3, 1'b1, 1'b1, 1'b0);
        check("sp_wr_valid", 32'(bus.wr_valid), 32'd1);
        check("sp_wr_addr", 32'(bus.wr_addr), 32'd3);
        check("sp_wr_data", 32'(bus.wr_data), 32'h2A);
        idle(1'b1);
        check("sp_count", 32'(count), 32'd0);
        check("sp_stat", 32'(stat_flags), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_flags = 4'd0;
        bus.in_dest  = '0;
        bus.in_we    = 1'b0;
        bus.wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_wr_we", 32'(bus.wr_we), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_stat", 32'(stat_flags), 32'd0);
        check("rst_sticky", 32'(stat_ovf_sticky), 32'd0);
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst_fwd_addr", 32'(fwd_addr), 32'd0);
        check("rst_fwd_data", 32'(fwd_data), 32'd0);
        n_reset = 1'b1;

        single_push_scenario();

        // back-to-back pushes into a stalled port; third one waits upstream
        drive(1'b1, 8'hA1, 4'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'hA2, 4'd4, 3'd2, 1'b1, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd2);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 8'hA3, 4'd8, 3'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'hA3, 4'd8, 3'd4, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'hA3, 4'd8, 3'd4, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("b2b_drained", 32'(count), 32'd0);

        // same destination twice: the younger one is forwarded
        drive(1'b1, 8'h11, 4'd0, 3'd5, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 4'd0, 3'd5, 1'b1, 1'b0, 1'b0);
        check("fwd_same_valid", 32'(fwd_valid), 32'd1);
        check("fwd_same_addr", 32'(fwd_addr), 32'd5);
        check("fwd_same_data", 32'(fwd_data), 32'h22);
        drive(1'b1, 8'h33, 4'd0, 3'd6, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'h33, 4'd0, 3'd6, 1'b0, 1'b0, 1'b0);
        check("fwd_we0_valid", 32'(fwd_valid), 32'd1);
        check("fwd_we0_addr", 32'(fwd_addr), 32'd5);
        check("fwd_we0_data", 32'(fwd_data), 32'h22);
        idle(1'b1);
        idle(1'b1);

        // overflow commit collides with clr_sticky; set wins
        drive(1'b1, 8'h90, 4'b1001, 3'd2, 1'b1, 1'b0, 1'b0);
        check("ovf_wr_data", 32'(bus.wr_data), 32'(OVF_DATA));
        drive(1'b0, 8'h00, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        check("ovf_sticky_set", 32'(stat_ovf_sticky), 32'd1);
        check("ovf_stat", 32'(stat_flags), 32'(OVF_FLAGS));
        drive(1'b0, 8'h00, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
        check("sticky_cleared", 32'(stat_ovf_sticky), 32'd0);

        // asynchronous reset while full
        drive(1'b1, 8'h44, 4'd1, 3'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 4'd0, 3'd2, 1'b1, 1'b0, 1'b0);
        check("prereset_count", 32'(count), 32'd2);
        bus.in_valid = 1'b0;
        n_reset = 1'b0;
        #1;
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("mrst_fwd_valid", 32'(fwd_valid), 32'd0);
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        m_flags  = 4'd0;
        m_sticky = 1'b0;
        @(negedge clk);
        #1;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        single_push_scenario();

        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, WIDTH'($urandom), 4'($urandom), AW'($urandom),
                  ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 8) == 0);
        end

        for (int c = 0; c < 10 && q.size() != 0; c++) idle(1'b1);
        check("drain_empty", 32'(q.size()), 32'd0);
        check("drain_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the ALU. It captures each ALU result with its flags and destination register into a 2-entry skid FIFO, then drives the register-file write port over a valid/ready handshake. It also maintains the architectural status flags and a sticky overflow bit, and exposes a forwarding path so the issue stage can bypass pending writes.

## Interface
- WIDTH, 8, datapath width; must match the ALU
- AW, 3, register address width
- clk  in  1  rising-edge clock
- n_reset  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_data  in  WIDTH  ALU result
- in_flags  in  4  ALU flags: [0] overflow, [1] reserved (passed through), [2] zero, [3] sign
- in_dest  in  AW  destination register
- in_we  in  1  instruction writes the register file
- wr_valid  out  1  head entry present
- wr_ready  in  1  register file accepts head
- wr_we  out  1  head entry write enable
- wr_addr  out  AW  head destination
- wr_data  out  WIDTH  head data
- stat_flags  out  4  flags of last committed entry
- stat_ovf_sticky  out  1  set by any committed overflow
- clr_sticky  in  1  clear sticky overflow
- fwd_valid  out  1  a pending entry has we=1
- fwd_addr  out  AW  destination of youngest pending we=1 entry
- fwd_data  out  WIDTH  data of that entry
- count  out  2  occupancy, 0..2

## Operation
- Push: in_valid && in_ready. Entry {data, flags, dest, we} is written at the tail.
- Commit: wr_valid && wr_ready. The head is popped.
- in_ready = (count != 2). There is no pass-through when full; upstream stalls.
- Every entry traverses the FIFO, including we=0 entries, so status ordering is preserved. On commit with wr_we=0, the register file ignores the data.
- Push and commit in the same cycle at count=1: count stays 1; the new entry becomes the head next cycle.
- On commit:
  - stat_flags <= head flags.
  - If head flags[0]=1, stat_ovf_sticky <= 1.
- clr_sticky clears stat_ovf_sticky. If clr_sticky and an overflow commit occur in the same cycle, set wins.
- Forwarding is purely combinational from FIFO state:
  - The youngest entry with we=1 is selected.
  - If both entries have the same dest and we=1, the younger one is forwarded.
  - fwd_valid=0 when no such entry exists.
- Data is carried unmodified at full WIDTH. Flags are not recomputed unless saturation is enabled.

## Timing
- Reset values:
  - count=0, wr_valid=0, in_ready=1, wr_we=0, wr_addr=0, wr_data=0.
  - stat_flags=0, stat_ovf_sticky=0.
  - fwd_valid=0, fwd_addr=0, fwd_data=0.
- Latency: a push at edge n gives wr_valid=1 and the head outputs valid after edge n. Minimum one cycle; there is no combinational path from in_* to wr_*.
- wr_* outputs are stable while wr_valid && !wr_ready.
- stat_* outputs update on the edge of the commit.
- in_ready depends only on registered count, never on wr_ready.
- Throughput: one entry per cycle while wr_ready stays high.
- Reset asserted mid-operation discards all entries immediately (asynchronous). No partial commit occurs.

## Configuration
- ALU_WB_SAT_EN defined: saturation is applied at push time when in_flags[0]=1.
  - in_flags[3]=1 (wrapped negative) stores data = 2^(WIDTH-1)-1 (0x7F for WIDTH=8).
  - in_flags[3]=0 stores data = -2^(WIDTH-1) (0x80).
  - Stored flags: [0]=1, [2]=0, [3]=sign of the saturated value, [1] passed through.
  - Sticky behaviour is unchanged.
- ALU_WB_SAT_EN undefined: wrapped data and flags are stored verbatim.

## Test plan
- Single push {data=0x2A, flags=0, dest=3, we=1} with wr_ready=1 -> next cycle wr_valid=1, wr_addr=3, wr_data=0x2A; commit -> count=0, stat_flags=0.
- Three back-to-back pushes with wr_ready=0 -> count=2, in_ready=0 after the second push, third entry held upstream. Then wr_ready=1 -> commits in order with no loss or duplication.
- Pushes of dest=5 data=0x11 then dest=5 data=0x22, both we=1, wr_ready=0 -> fwd_valid=1, fwd_addr=5, fwd_data=0x22. Push of a we=0 entry -> fwd_valid=1, fwd_addr=5, fwd_data=0x22 unchanged.
- Commit of an entry with flags=4'b1000 and overflow bit set (in_flags=4'b1001), data=0x90:
  - without the macro -> wr_data=0x90, stat_ovf_sticky=1;
  - with ALU_WB_SAT_EN -> wr_data=0x7F, stat_flags=4'b0001.
- clr_sticky in the same cycle as an overflow commit -> sticky stays 1. clr_sticky on the next cycle with no overflow -> sticky=0.
- n_reset low while count=2 -> count=0, wr_valid=0, fwd_valid=0 and in_ready=1 immediately. First push after release behaves as in the single-push scenario.
